// File: rtl/volume_meter_if.sv
// Sample-in / level-out bundle for the audio peak meter.
// Latency: n/a (wires only); the meter decides timing.
// Backpressure: none; samples are never stalled and there is no ready signal.
//
// Signals:
//   sample_valid  qualifies sample for one cycle
//   sample        signed 16-bit two's-complement audio sample
//   peak          unsigned absolute peak of the last completed window
//   level         4-bit volume level decoded from peak
//   level_valid   one-cycle pulse when level and peak update
//   busy          high while the divider is running
interface volume_meter_if;
    logic        sample_valid;
    logic [15:0] sample;
    logic [15:0] peak;
    logic [3:0]  level;
    logic        level_valid;
    logic        busy;

    // Sample source side (audio path / testbench).
    modport master (
        output sample_valid,
        output sample,
        input  peak,
        input  level,
        input  level_valid,
        input  busy
    );

    // Meter side.
    modport slave (
        input  sample_valid,
        input  sample,
        output peak,
        output level,
        output level_valid,
        output busy
    );
endinterface

// File: rtl/volume_meter.sv
// Audio peak meter: per-window absolute peak, decoded to a 4-bit volume level.
// Latency: level_valid pulses q+1 cycles after the window's last sample edge (1..17).
// Backpressure: none; a new window accumulates while the previous one divides.
//
// Ports:
//   clk    rising-edge system clock
//   rst_n  synchronous active-low reset
//   vm     volume_meter_if.slave: sample_valid/sample in,
//          peak/level/level_valid/busy out
//
// The level is the inverse of amplitude = STEP * (level + 1):
//   q = floor(peak / STEP) capped at 16, level = 0 if q == 0 else q - 1.
// The division is repeated subtraction, one step per cycle.
module volume_meter #(
    parameter int WINDOW = 32,    // samples per window, 32..65535
    parameter int STEP   = 1400   // amplitude units per volume step, nonzero
) (
    input  logic          clk,
    input  logic          rst_n,
    volume_meter_if.slave vm
);

    localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
    localparam logic [15:0] STEP_U   = 16'(STEP);
    localparam logic [4:0]  Q_MAX    = 5'd16;

    typedef enum logic {
        ACC = 1'b0,   // accumulating only, divider idle
        DIV = 1'b1    // dividing the last window's peak
    } state_t;

    state_t      state, state_nxt;

    // Window accumulator.
    logic [15:0] win_cnt, win_cnt_nxt;
    logic [15:0] acc_peak, acc_peak_nxt;

    // Divider: remainder, quotient and the peak being decoded.
    logic [15:0] r, r_nxt;
    logic [4:0]  q, q_nxt;
    logic [15:0] peak_hold, peak_hold_nxt;

    // Published outputs.
    logic [15:0] peak_q, peak_nxt;
    logic [3:0]  level_q, level_nxt;
    logic        level_valid_q, level_valid_nxt;

    logic [15:0] mag;
    logic [15:0] snap;
    logic        win_close;
    logic [3:0]  level_dec;
    logic        div_step;

    // Absolute value in 16 bits; -32768 has no positive twin so it saturates.
    always_comb begin
        mag = vm.sample;
        if (vm.sample == 16'h8000) begin
            mag = 16'h7FFF;
        end else if (vm.sample[15]) begin
            mag = (~vm.sample) + 16'd1;
        end
    end

    assign win_close = vm.sample_valid && (win_cnt == WIN_LAST);

    // The closing sample belongs to the closing window, so fold it in here.
    assign snap = (mag > acc_peak) ? mag : acc_peak;

    // Keep subtracting while another whole STEP fits; q stops at 16 because
    // every level from 16*STEP upward saturates to 15 anyway.
    assign div_step = (r >= STEP_U) && (q < Q_MAX);

    // q ranges 0..16, so q-1 already lands in 0..15 when q is nonzero.
    assign level_dec = (q == 5'd0) ? 4'd0 : 4'(q - 5'd1);

    // Next-state and datapath.
    always_comb begin
        state_nxt       = state;
        win_cnt_nxt     = win_cnt;
        acc_peak_nxt    = acc_peak;
        r_nxt           = r;
        q_nxt           = q;
        peak_hold_nxt   = peak_hold;
        peak_nxt        = peak_q;
        level_nxt       = level_q;
        level_valid_nxt = 1'b0;

        // The accumulator runs regardless of divider state.
        if (vm.sample_valid) begin
            if (win_close) begin
                win_cnt_nxt  = 16'd0;
                acc_peak_nxt = 16'd0;
            end else begin
                win_cnt_nxt  = win_cnt + 16'd1;
                acc_peak_nxt = snap;
            end
        end

        case (state)
            ACC: begin
                if (win_close) begin
                    state_nxt     = DIV;
                    r_nxt         = snap;
                    q_nxt         = 5'd0;
                    peak_hold_nxt = snap;
                end
            end
            DIV: begin
                if (div_step) begin
                    r_nxt = r - STEP_U;
                    q_nxt = q + 5'd1;
                end else begin
                    level_nxt       = level_dec;
                    peak_nxt        = peak_hold;
                    level_valid_nxt = 1'b1;
                    state_nxt       = ACC;
                end
            end
            default: begin
                state_nxt = ACC;
            end
        endcase
    end

    // State register; reset abandons any division without a pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ACC;
            win_cnt       <= 16'd0;
            acc_peak      <= 16'd0;
            r             <= 16'd0;
            q             <= 5'd0;
            peak_hold     <= 16'd0;
            peak_q        <= 16'd0;
            level_q       <= 4'd0;
            level_valid_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            win_cnt       <= win_cnt_nxt;
            acc_peak      <= acc_peak_nxt;
            r             <= r_nxt;
            q             <= q_nxt;
            peak_hold     <= peak_hold_nxt;
            peak_q        <= peak_nxt;
            level_q       <= level_nxt;
            level_valid_q <= level_valid_nxt;
        end
    end

    assign vm.peak        = peak_q;
    assign vm.level       = level_q;
    assign vm.level_valid = level_valid_q;
    assign vm.busy        = (state == DIV);

    // A window is at least 32 samples and a division at most 17 cycles, so a
    // window can never close while the divider is still busy.
    a_no_close_in_div: assert property (
        @(posedge clk) disable iff (!rst_n) !((state == DIV) && win_close)
    );

endmodule
